// File: rtl/lbm_sweep_sequencer_if.sv
// lbm_sweep_sequencer_if: node request handshake between the sweep sequencer and the node compute core
interface lbm_sweep_sequencer_if #(
  parameter int X_W = 4,
  parameter int Y_W = 4
);
  logic           Node_valid;
  logic           Node_ready;
  logic [X_W-1:0] Node_x;
  logic [Y_W-1:0] Node_y;
  logic           Phase;
  modport master (output Node_valid, Node_x, Node_y, Phase, input Node_ready);
  modport slave  (input Node_valid, Node_x, Node_y, Phase, output Node_ready);
endinterface

// File: rtl/lbm_sweep_sequencer.sv
// lbm_sweep_sequencer: raster-sweeps the lattice through collide then stream per time step,
// pulses Step_en after each step and stops once MAX_TIME steps have completed.
module lbm_sweep_sequencer #(
  parameter int NX               = 16,
  parameter int NY               = 16,
  parameter int MAX_TIME         = 8,
  parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME),
  parameter int X_W              = $clog2(NX),
  parameter int Y_W              = $clog2(NY)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [TIME_COUNT_WIDTH:0] Time_count,
  lbm_sweep_sequencer_if.master     nif,
  output logic                      Step_en,
  output logic                      Busy,
  output logic                      Done
);
  typedef enum logic [2:0] {S_IDLE, S_COLLIDE, S_STREAM, S_STEP, S_DONE} state_t;
  localparam logic [X_W-1:0]              X_LAST = X_W'(NX - 1);
  localparam logic [Y_W-1:0]              Y_LAST = Y_W'(NY - 1);
  localparam logic [TIME_COUNT_WIDTH:0]   T_MAX  = (TIME_COUNT_WIDTH + 1)'(MAX_TIME);
  localparam logic [TIME_COUNT_WIDTH:0]   T_LAST = (TIME_COUNT_WIDTH + 1)'(MAX_TIME - 1);
  state_t         r_state, w_nxt;
  logic [X_W-1:0] r_x, w_x;
  logic [Y_W-1:0] r_y, w_y;
  logic           r_valid, r_phase, r_step, r_busy, r_done;
  logic           w_valid, w_phase, w_step, w_busy, w_done;
  logic           w_hs, w_last_x, w_last_y;
  assign w_hs     = r_valid & nif.Node_ready;
  assign w_last_x = r_x == X_LAST;
  assign w_last_y = r_y == Y_LAST;
  always_comb begin
    w_nxt = r_state;
    w_x   = r_x;
    w_y   = r_y;
    unique case (r_state)
      S_IDLE: if (Start) begin
        w_nxt = (Time_count >= T_MAX) ? S_DONE : S_COLLIDE;
        w_x   = '0;
        w_y   = '0;
      end
      S_COLLIDE, S_STREAM: if (w_hs) begin
        w_x = w_last_x ? '0 : r_x + X_W'(1);
        w_y = w_last_x ? (w_last_y ? '0 : r_y + Y_W'(1)) : r_y;
        if (w_last_x && w_last_y) w_nxt = (r_state == S_COLLIDE) ? S_STREAM : S_STEP;
      end
      // Time_count still holds the pre-increment value while in STEP
      S_STEP: w_nxt = (Time_count >= T_LAST) ? S_DONE : S_COLLIDE;
      default: ;
    endcase
    w_valid = (w_nxt == S_COLLIDE) || (w_nxt == S_STREAM);
    w_phase = w_nxt == S_STREAM;
    w_step  = w_nxt == S_STEP;
    w_busy  = w_valid || w_step;
    w_done  = w_nxt == S_DONE;
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_phase <= 1'b0;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_x     <= w_x;
      r_y     <= w_y;
      r_valid <= w_valid;
      r_phase <= w_phase;
      r_step  <= w_step;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end
  assign nif.Node_valid = r_valid;
  assign nif.Node_x     = r_x;
  assign nif.Node_y     = r_y;
  assign nif.Phase      = r_phase;
  assign Step_en        = r_step;
  assign Busy           = r_busy;
  assign Done           = r_done;
endmodule

// File: tb/tb_lbm_sweep_sequencer.sv
// tb_lbm_sweep_sequencer: directed vectors plus multi-cycle runs against a time-step counter model
module tb_lbm_sweep_sequencer;
  localparam int NX = 4, NY = 4, MT = 8, TW = $clog2(MT), NN = NX * NY;
  typedef struct {
    logic       st;
    logic [TW:0] tc;
    logic       rdy;
    logic       v;
    logic [1:0] x;
    logic [1:0] y;
    logic       ph;
    logic       se;
    logic       bz;
    logic       dn;
  } vec_t;
  logic        Clk = 1'b0, Reset = 1'b1, Start = 1'b0, use_model = 1'b0, cnt_clr = 1'b0;
  logic [TW:0] tc_man = '0, cnt = '0, Time_count;
  logic        Step_en, Busy, Done;
  int          checks = 0, errors = 0;
  vec_t        tbl[10];
  lbm_sweep_sequencer_if #(.X_W(2), .Y_W(2)) nif();
  lbm_sweep_sequencer #(.NX(NX), .NY(NY), .MAX_TIME(MT)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Time_count(Time_count),
    .nif(nif), .Step_en(Step_en), .Busy(Busy), .Done(Done)
  );
  always #10 Clk = ~Clk;
  assign Time_count = use_model ? cnt : tc_man;
  always @(posedge Clk) begin
    if (cnt_clr) cnt <= '0;
    else if (Step_en) cnt <= cnt + 1'b1;
  end
  function automatic logic [8:0] outs();
    return {nif.Node_valid, nif.Node_x, nif.Node_y, nif.Phase, Step_en, Busy, Done};
  endfunction
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic rst_pulse();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
  endtask
  task automatic run(input bit rnd);
    int c, idx, steps;
    logic prev_step;
    use_model = 1'b1;
    cnt_clr = 1'b1;
    nif.Node_ready = 1'b0;
    tick();
    cnt_clr = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("run_first_valid", nif.Node_valid, 1);
    c = 0; idx = 0; steps = 0; prev_step = 1'b0;
    while (!Done && c < 3000) begin
      if (nif.Node_valid) begin
        chk("hs_overrun", idx < 2 * NN, 1);
        chk("node_tuple", {nif.Phase, nif.Node_x, nif.Node_y},
            {1'(idx / NN), 2'((idx % NN) % NX), 2'((idx % NN) / NX)});
        chk("busy_valid", Busy, 1);
      end
      if (Step_en) begin
        chk("step_idx", idx, 2 * NN);
        if (!rnd) chk("step_cycle", c, 32 + 33 * steps);
        chk("step_novalid", nif.Node_valid, 0);
        chk("step_busy", Busy, 1);
        steps++;
        idx = 0;
      end
      chk("step_repeat", prev_step & Step_en, 0);
      prev_step = Step_en;
      nif.Node_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (nif.Node_valid && nif.Node_ready) idx++;
      tick();
      c++;
    end
    chk("run_done", Done, 1);
    chk("run_steps", steps, MT);
    chk("run_count", cnt, MT);
    chk("run_idle_outs", {nif.Node_valid, Step_en, Busy}, 0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("done_sticky", {nif.Node_valid, Step_en, Busy, Done}, 4'b0001);
      tick();
    end
  endtask
  initial begin
    nif.Node_ready = 1'b0;
    tbl[0] = '{1'b0, 4'd8, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 4'd7, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 4'd0, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 4'd8, 1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 4'd0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 4'd0, 1'b1, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 4'd0, 1'b1, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 4'd0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 4'd0, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    #2 Reset = 1'b0;
    #1 chk("reset_async", outs(), 0);
    tick();
    tick();
    Reset = 1'b1;
    tick();
    chk("reset_release", outs(), 0);
    use_model = 1'b0;
    foreach (tbl[i]) begin
      Start = tbl[i].st;
      tc_man = tbl[i].tc;
      nif.Node_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].ph, tbl[i].se, tbl[i].bz, tbl[i].dn});
    end
    Start = 1'b0;
    nif.Node_ready = 1'b0;
    rst_pulse();
    tc_man = 4'd8;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start_at_max", outs(), 9'b0_00_00_0_0_0_1);
    tick();
    chk("start_at_max_hold", outs(), 9'b0_00_00_0_0_0_1);
    rst_pulse();
    run(1'b0);
    rst_pulse();
    run(1'b1);
    rst_pulse();
    use_model = 1'b0;
    tc_man = '0;
    nif.Node_ready = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 64 && !(nif.Phase && nif.Node_x == 2'd2 && nif.Node_y == 2'd1); k++) tick();
    chk("reach_stream_2_1", {nif.Node_valid, nif.Phase, nif.Node_x, nif.Node_y}, 6'b1_1_10_01);
    #3 Reset = 1'b0;
    #1 chk("reset_midrun", outs(), 0);
    tick();
    Reset = 1'b1;
    tick();
    chk("after_reset_idle", outs(), 0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("restart_collide", outs(), 9'b1_00_00_0_0_1_0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
